// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler
// Issue-stage scheduler for the integer, load/store, multiplier and divider
// execution units. It grants at most one ready queue per cycle. A grant is
// given only when the unit's result will find the common data bus (CDB) free
// after the unit's fixed latency.
//
// Optional build macro: CDB_RR_ARB_EN
//   defined   : round-robin selection in the order int, mem, mul, div
//               (last-granted pointer register present)
//   undefined : fixed priority int > mem > mul > div
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   int/mul/div/mem_req  per-queue "ready instruction" requests
//   mem_is_store      ld/st queue head is a store (no CDB result)
//   int/mul/div/mem_grant  one-hot (or zero) issue grants
//   cdb_rsv           reservation vector, bit k = CDB slot k cycles ahead owned
//   div_busy          non-pipelined divider occupied
module cdb_issue_scheduler #(
    parameter int INT_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int MEM_LAT = 1,
    localparam int LAT_A  = (INT_LAT > MUL_LAT) ? INT_LAT : MUL_LAT,
    localparam int LAT_B  = (DIV_LAT > MEM_LAT) ? DIV_LAT : MEM_LAT,
    localparam int RSV_DEPTH = ((LAT_A > LAT_B) ? LAT_A : LAT_B) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 int_req,
    input  logic                 mul_req,
    input  logic                 div_req,
    input  logic                 mem_req,
    input  logic                 mem_is_store,
    output logic                 int_grant,
    output logic                 mul_grant,
    output logic                 div_grant,
    output logic                 mem_grant,
    output logic [RSV_DEPTH-1:0] cdb_rsv,
    output logic                 div_busy
);

    localparam int DCW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    // Arbitration positions: 0 int, 1 mem, 2 mul, 3 div
    logic [3:0]           elig;
    logic [3:0]           gnt;
    logic [RSV_DEPTH-1:0] rsv_set;
    logic [DCW-1:0]       div_cnt;

    assign div_busy = (div_cnt != '0);

    // A result issued now with latency L lands on the CDB L cycles from now,
    // which is exactly what bit L of the current vector describes.
    always_comb begin
        elig    = '0;
        elig[0] = int_req & ~cdb_rsv[INT_LAT];
        elig[1] = mem_req & (mem_is_store | ~cdb_rsv[MEM_LAT]);
        elig[2] = mul_req & ~cdb_rsv[MUL_LAT];
        elig[3] = div_req & ~div_busy & ~cdb_rsv[DIV_LAT];
    end

`ifdef CDB_RR_ARB_EN
    logic [1:0] ptr;       // last granted position
    logic [1:0] gnt_idx;
    logic [1:0] idx;
    logic       found;

    // Search starts one position after the last winner and wraps.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        case (gnt)
            4'b0010: gnt_idx = 2'd1;
            4'b0100: gnt_idx = 2'd2;
            4'b1000: gnt_idx = 2'd3;
            default: gnt_idx = 2'd0;
        endcase
    end

    // Reset value makes int the first position searched after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 2'd3;
        else if (|gnt)
            ptr <= gnt_idx;
    end
`else
    // Fixed priority: lowest position wins (descending loop, last write wins).
    always_comb begin
        gnt = '0;
        for (int k = 3; k >= 0; k--) begin
            if (elig[k])
                gnt = 4'b0001 << k;
        end
    end
`endif

    assign int_grant = gnt[0];
    assign mem_grant = gnt[1];
    assign mul_grant = gnt[2];
    assign div_grant = gnt[3];

    // Slot claimed by this cycle's grant: bit L-1 after the shift, so it
    // reaches index 0 exactly L cycles from now. Stores claim nothing.
    always_comb begin
        rsv_set = '0;
        if (gnt[0])                 rsv_set[INT_LAT-1] = 1'b1;
        if (gnt[1] && !mem_is_store) rsv_set[MEM_LAT-1] = 1'b1;
        if (gnt[2])                 rsv_set[MUL_LAT-1] = 1'b1;
        if (gnt[3])                 rsv_set[DIV_LAT-1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_rsv <= '0;
            div_cnt <= '0;
        end else begin
            cdb_rsv <= (cdb_rsv >> 1) | rsv_set;
            // Loading DIV_LAT-1 spaces back-to-back divides DIV_LAT cycles apart.
            if (gnt[3])
                div_cnt <= DCW'(DIV_LAT - 1);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule
